// File: rtl/tensor_core_mma_seq.sv
// Operand sequencer for the FP16 tensor-core MMA datapath: issues A/B dot steps,
// waits out the datapath latency and returns one accumulator value per tile element.
module tensor_core_mma_seq #(
    parameter int NUM    = 4,
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 92,
    parameter int KW     = 8,
    parameter int LAT    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_start,
    input  logic [KW-1:0]            cfg_ksteps,
    input  logic                     cfg_abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [NUM*DWIDTH-1:0]    op_a,
    input  logic [NUM*DWIDTH-1:0]    op_b,
    output logic [NUM*DWIDTH-1:0]    mma_a,
    output logic [NUM*DWIDTH-1:0]    mma_b,
    output logic                     mma_issue,
    output logic                     mma_first,
    input  logic [AWIDTH-1:0]        mma_acc,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [AWIDTH-1:0]        res_data,
    output logic [((NUM > 1) ? $clog2(NUM) : 1)-1:0] res_row,
    output logic [((NUM > 1) ? $clog2(NUM) : 1)-1:0] res_col
);

    localparam int CW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int IW = (NUM > 1) ? $clog2(NUM * NUM) : 1;
    localparam int DW = $clog2(LAT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM * NUM - 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} state_t;

    state_t                  state_q;
    logic [KW-1:0]           ksteps_q;
    logic [KW-1:0]           kcnt_q;
    logic [IW-1:0]           idx_q;
    logic [DW-1:0]           dcnt_q;
    logic                    done_q;
    logic                    err_q;
    logic                    issue_q;
    logic                    first_q;
    logic [NUM*DWIDTH-1:0]   a_q;
    logic [NUM*DWIDTH-1:0]   b_q;
    logic [AWIDTH-1:0]       res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ksteps_q <= '0;
            kcnt_q   <= '0;
            idx_q    <= '0;
            dcnt_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            issue_q  <= 1'b0;
            first_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            issue_q <= 1'b0;
            first_q <= 1'b0;
            // Abort wins over everything, including a handshake in the same cycle.
            if (cfg_abort && state_q != IDLE) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cfg_start) begin
                            if (cfg_ksteps == '0) begin
                                err_q <= 1'b1;
                            end else begin
                                ksteps_q <= cfg_ksteps;
                                kcnt_q   <= '0;
                                idx_q    <= '0;
                                state_q  <= FEED;
                            end
                        end
                    end
                    FEED: begin
                        if (op_valid) begin
                            a_q     <= op_a;
                            b_q     <= op_b;
                            issue_q <= 1'b1;
                            first_q <= (kcnt_q == '0);
                            kcnt_q  <= kcnt_q + 1'b1;
                            if (kcnt_q == ksteps_q - 1'b1) begin
                                state_q <= DRAIN;
                                dcnt_q  <= DW'(LAT);
                            end
                        end
                    end
                    DRAIN: begin
                        if (dcnt_q == '0) begin
                            res_q   <= mma_acc;
                            state_q <= OUT;
                        end else begin
                            dcnt_q <= dcnt_q - 1'b1;
                        end
                    end
                    OUT: begin
                        if (res_ready) begin
                            if (idx_q == LAST_IDX) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                idx_q   <= idx_q + 1'b1;
                                kcnt_q  <= '0;
                                state_q <= FEED;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign op_ready  = (state_q == FEED);
    assign res_valid = (state_q == OUT);
    assign done      = done_q;
    assign err       = err_q;
    assign mma_a     = a_q;
    assign mma_b     = b_q;
    assign mma_issue = issue_q;
    assign mma_first = first_q;
    assign res_data  = res_q;
    assign res_row   = CW'(idx_q / IW'(NUM));
    assign res_col   = CW'(idx_q % IW'(NUM));

endmodule

// File: tb/tb_tensor_core_mma_seq.sv
// Scoreboard bench for tensor_core_mma_seq with a behavioural MMA datapath model
// (integer dot product, LAT-cycle latency, poison value outside the valid cycle).
module tb_tensor_core_mma_seq;

    localparam int NUM = 4;
    localparam int DW  = 16;
    localparam int AW  = 92;
    localparam int KW  = 8;
    localparam int LAT = 2;
    localparam int OW  = NUM * DW;
    localparam logic [AW-1:0] POISON = 92'h5A5_A5A5_A5A5_A5A5_A5A5_A5A5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_start = 1'b0;
    logic [KW-1:0]  cfg_ksteps = '0;
    logic           cfg_abort = 1'b0;
    logic           busy, done, err;
    logic           op_valid = 1'b0;
    logic           op_ready;
    logic [OW-1:0]  op_a = '0;
    logic [OW-1:0]  op_b = '0;
    logic [OW-1:0]  mma_a, mma_b;
    logic           mma_issue, mma_first;
    logic [AW-1:0]  mma_acc;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic [AW-1:0]  res_data;
    logic [1:0]     res_row, res_col;

    tensor_core_mma_seq #(
        .NUM(NUM), .DWIDTH(DW), .AWIDTH(AW), .KW(KW), .LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_ksteps(cfg_ksteps), .cfg_abort(cfg_abort),
        .busy(busy), .done(done), .err(err),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mma_a(mma_a), .mma_b(mma_b), .mma_issue(mma_issue), .mma_first(mma_first),
        .mma_acc(mma_acc),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_row(res_row), .res_col(res_col)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
    endtask

    function automatic logic [AW-1:0] dotp(input logic [OW-1:0] a, input logic [OW-1:0] b);
        logic [AW-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < NUM; i++)
            s += AW'(a[i*DW +: DW]) * AW'(b[i*DW +: DW]);
        return s;
    endfunction

    function automatic logic [OW-1:0] opa(input int unsigned o, input int unsigned k);
        logic [OW-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM; i++) v[i*DW +: DW] = DW'(o * 8 + k * 3 + i + 1);
        return v;
    endfunction

    function automatic logic [OW-1:0] opb(input int unsigned o, input int unsigned k);
        logic [OW-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM; i++) v[i*DW +: DW] = DW'(100 + o * 5 + k * 7 + i * 11);
        return v;
    endfunction

    // Datapath model: value appears on mma_acc exactly LAT cycles after its issue.
    logic [AW-1:0] m_acc = '0, s1 = '0, s2 = '0, acc_now;
    logic          v1 = 1'b0, v2 = 1'b0;
    always_comb acc_now = (mma_first ? '0 : m_acc) + dotp(mma_a, mma_b);
    always @(posedge clk) begin
        if (mma_issue) m_acc <= acc_now;
        s1 <= acc_now;
        v1 <= mma_issue;
        s2 <= s1;
        v2 <= v1;
    end
    assign mma_acc = v2 ? s2 : POISON;

    typedef struct packed {
        logic [AW-1:0] d;
        logic [1:0]    r;
        logic [1:0]    c;
    } exp_t;
    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned hs_cyc[$];
    int unsigned res_cnt = 0, done_cnt = 0, done_cyc = 0;
    logic        busy_at_done = 1'b0;
    int unsigned issue_cnt = 0, issue_k = 0, first_bad = 0, cur_ks = 1;

    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            hs_cyc.push_back(cyc);
            res_cnt++;
            if (exp_q.size() == 0) begin
                chk("result_without_expectation", 128'(exp_q.size()), 128'(1));
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_data", 128'(res_data), 128'(mon_e.d));
                chk("res_row", 128'(res_row), 128'(mon_e.r));
                chk("res_col", 128'(res_col), 128'(mon_e.c));
            end
        end
        if (mma_issue) begin
            issue_cnt++;
            if (mma_first !== (issue_k == 0)) first_bad++;
            issue_k = (issue_k + 1 == cur_ks) ? 0 : issue_k + 1;
        end
        if (mma_first && !mma_issue) first_bad++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
    end

    int unsigned t0 = 0;
    bit          stop_feed = 1'b0;

    task automatic start_tile(input int unsigned ks);
        @(posedge clk); #1;
        cfg_start  = 1'b1;
        cfg_ksteps = KW'(ks);
        t0 = cyc;
        @(posedge clk); #1;
        cfg_start  = 1'b0;
        cfg_ksteps = 8'd99;
    endtask

    task automatic feed(input int unsigned ks, input bit toggle);
        logic [AW-1:0] sum;
        logic [OW-1:0] a, b;
        bit            hs;
        int unsigned   guard;
        for (int unsigned o = 0; o < NUM * NUM; o++) begin
            sum = '0;
            for (int unsigned k = 0; k < ks; k++) begin
                a = opa(o, k);
                b = opb(o, k);
                if (toggle) begin
                    op_valid = 1'b0;
                    @(posedge clk); #1;
                end
                op_a = a;
                op_b = b;
                op_valid = 1'b1;
                hs = 1'b0;
                guard = 0;
                while (!hs && !stop_feed && guard < 200) begin
                    @(negedge clk);
                    hs = op_ready;
                    @(posedge clk); #1;
                    guard++;
                end
                if (!hs) begin
                    if (!stop_feed) chk("op_handshake_timeout", 128'(guard), 128'(0));
                    op_valid = 1'b0;
                    return;
                end
                sum += dotp(a, b);
            end
            exp_q.push_back('{d: sum, r: 2'(o / NUM), c: 2'(o % NUM)});
        end
        op_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int unsigned d0);
        int unsigned g;
        g = 0;
        while (done_cnt == d0 && g < 300) begin
            @(negedge clk); #1;
            g++;
        end
        chk(name, 128'(done_cnt - d0), 128'(1));
    endtask

    task automatic wait_res_valid(input string name);
        int unsigned g;
        g = 0;
        while (!res_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk(name, 128'(res_valid), 128'(1));
    endtask

    task automatic reset_stats(input int unsigned ks);
        cur_ks = ks;
        issue_cnt = 0;
        issue_k = 0;
        first_bad = 0;
        hs_cyc.delete();
        stop_feed = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned dc0, rc0, errs, g;
        bit          seen_busy, seen_ready, stable, bad;
        logic [AW-1:0] hd;
        logic [1:0]    hr, hc;

        // Reset state
        #12;
        chk("reset_ctrl", 128'({busy, done, err, op_ready, mma_issue, mma_first, res_valid}), 128'(0));
        chk("reset_data", 128'({mma_a, mma_b, res_data, res_row, res_col}), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", 128'({busy, op_ready}), 128'(0));

        // Zero-step start is rejected with a single err pulse
        @(posedge clk); #1;
        cfg_start = 1'b1;
        cfg_ksteps = '0;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        chk("err_next_cycle", 128'(err), 128'(1));
        errs = 1; seen_busy = busy; seen_ready = op_ready;
        repeat (6) begin
            @(negedge clk);
            if (err) errs++;
            if (busy) seen_busy = 1'b1;
            if (op_ready) seen_ready = 1'b1;
        end
        chk("err_pulse_len", 128'(errs), 128'(1));
        chk("err_busy", 128'(seen_busy), 128'(0));
        chk("err_op_ready", 128'(seen_ready), 128'(0));

        // Abort during DRAIN of output 5
        reset_stats(1);
        dc0 = done_cnt;
        rc0 = res_cnt;
        start_tile(1);
        fork
            feed(1, 1'b0);
            begin
                g = 0;
                while (res_cnt != rc0 + 5 && g < 200) begin
                    @(negedge clk); #1;
                    g++;
                end
                g = 0;
                while (!mma_issue && g < 50) begin
                    @(negedge clk); #1;
                    g++;
                end
                chk("abort_reached_drain", 128'(mma_issue), 128'(1));
                #2 cfg_abort = 1'b1;
                @(posedge clk); #1;
                cfg_abort = 1'b0;
                stop_feed = 1'b1;
                @(negedge clk);
                chk("abort_idle", 128'({busy, res_valid, op_ready}), 128'(0));
                bad = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    if (res_valid || done || busy) bad = 1'b1;
                end
                chk("abort_quiet", 128'(bad), 128'(0));
            end
        join
        exp_q.delete();
        chk("abort_no_done", 128'(done_cnt - dc0), 128'(0));
        chk("abort_results", 128'(res_cnt - rc0), 128'(5));

        // Full throughput, ksteps=1
        reset_stats(1);
        dc0 = done_cnt;
        start_tile(1);
        feed(1, 1'b0);
        wait_done("t1_done", dc0);
        chk("t1_results", 128'(hs_cyc.size()), 128'(16));
        if (hs_cyc.size() == 16) begin
            chk("t1_res0_cycle", 128'(hs_cyc[0] - t0), 128'(5));
            chk("t1_res1_cycle", 128'(hs_cyc[1] - t0), 128'(10));
            chk("t1_res15_cycle", 128'(hs_cyc[15] - t0), 128'(80));
        end
        chk("t1_done_cycle", 128'(done_cyc - t0), 128'(81));
        chk("t1_busy_at_done", 128'(busy_at_done), 128'(0));
        chk("t1_issues", 128'(issue_cnt), 128'(16));
        chk("t1_first", 128'(first_bad), 128'(0));

        // ksteps=3 with op_valid toggling
        reset_stats(3);
        dc0 = done_cnt;
        start_tile(3);
        feed(3, 1'b1);
        wait_done("t2_done", dc0);
        chk("t2_issues", 128'(issue_cnt), 128'(48));
        chk("t2_first", 128'(first_bad), 128'(0));
        chk("t2_results", 128'(hs_cyc.size()), 128'(16));

        // ksteps=2 with res_ready held low in OUT
        reset_stats(2);
        dc0 = done_cnt;
        res_ready = 1'b0;
        start_tile(2);
        fork
            feed(2, 1'b0);
            begin
                wait_res_valid("t3_res_valid");
                hd = res_data; hr = res_row; hc = res_col;
                stable = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (!res_valid || res_data !== hd || res_row !== hr || res_col !== hc ||
                        op_ready || mma_issue) stable = 1'b0;
                end
                chk("t3_hold_stable", 128'(stable), 128'(1));
                @(posedge clk); #1;
                res_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("t3_op_ready_after", 128'({op_ready, res_valid}), 128'(2'b10));
            end
        join
        wait_done("t3_done", dc0);
        chk("t3_issues", 128'(issue_cnt), 128'(32));

        // Asynchronous reset in OUT
        reset_stats(1);
        res_ready = 1'b0;
        start_tile(1);
        fork
            feed(1, 1'b0);
            begin
                wait_res_valid("t6_res_valid");
                #2 rst_n = 1'b0;
                #1;
                chk("async_reset_ctrl",
                    128'({busy, done, err, op_ready, mma_issue, mma_first, res_valid}), 128'(0));
                chk("async_reset_mma", 128'({mma_a, mma_b}), 128'(0));
                chk("async_reset_res", 128'({res_data, res_row, res_col}), 128'(0));
                stop_feed = 1'b1;
                @(posedge clk); #1;
                rst_n = 1'b1;
                bad = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    if (busy || op_ready || res_valid || mma_issue) bad = 1'b1;
                end
                chk("t6_idle_after_release", 128'(bad), 128'(0));
            end
        join
        exp_q.delete();
        res_ready = 1'b1;
        op_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tensor_core_mma_seq.md
# tensor_core_mma_seq

Sequencer for the FP16 tensor-core MMA datapath (Booth multipliers plus Kulisch accumulator). It accepts a stream of operand pairs, each a 4-element A row slice and a 4-element B column slice, and issues them to the datapath. It marks the first step of each dot product so the accumulator clears, then waits out the datapath latency. It returns one accumulated AWIDTH-bit result per output element of a NUM×NUM tile, in row-major order, and sits between the operand-fetch logic and the MMA datapath.

## Interface
- NUM, 4, elements per dot step; tile is NUM×NUM outputs
- DWIDTH, 16, FP16 element width
- AWIDTH, 92, Kulisch accumulator width
- KW, 8, width of the dot-step count
- LAT, 2, cycles from mma_issue to a valid mma_acc (must be ≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  start a tile; sampled in IDLE only
- cfg_ksteps  in  KW  dot steps per output element; sampled with cfg_start
- cfg_abort  in  1  abandon the current tile
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last result is accepted
- err  out  1  one-cycle pulse when a start is rejected
- op_valid  in  1  operand pair valid
- op_ready  out  1  high in FEED only
- op_a, op_b  in  NUM*DWIDTH  A row slice, B column slice
- mma_a, mma_b  out  NUM*DWIDTH  registered operands to the datapath
- mma_issue  out  1  operands valid this cycle
- mma_first  out  1  with mma_issue: first step, accumulator takes C=0
- mma_acc  in  AWIDTH  accumulator value from the datapath
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_data  out  AWIDTH  captured accumulator
- res_row, res_col  out  $clog2(NUM)  output coordinates: idx/NUM, idx%NUM

## Operation
- States: IDLE, FEED, DRAIN, OUT.
- Counters:
  - kcnt (KW bits): dot steps issued for the current output.
  - idx (0..NUM*NUM-1): current output element.
  - dcnt: drain countdown.
- IDLE:
  - cfg_start with cfg_ksteps≠0: latch ksteps, clear kcnt and idx, go to FEED.
  - cfg_start with cfg_ksteps=0: pulse err next cycle, stay in IDLE.
- FEED (op_ready=1):
  - On op_valid&op_ready: register op_a/op_b into mma_a/mma_b. mma_issue=1 on the next cycle; mma_first=1 with it if kcnt was 0. Increment kcnt.
  - If the handshake is step ksteps-1: go to DRAIN and load dcnt=LAT.
- DRAIN (op_ready=0): decrement dcnt each cycle. In the cycle dcnt=0, capture mma_acc into res_data and go to OUT.
- OUT: res_valid=1; res_data, res_row and res_col stay stable until res_ready.
  - On res_ready with idx=NUM*NUM-1: go to IDLE and pulse done.
  - Otherwise: increment idx, clear kcnt, go to FEED.
- cfg_abort (any non-IDLE state): IDLE on the next cycle. No done pulse. res_valid and mma_issue drop. The final issue in flight is suppressed only if it is not yet driven.
- cfg_start while busy is ignored. cfg_abort has priority over every other transition.
- mma_issue and mma_first are single-cycle pulses, and mma_first never occurs without mma_issue.
- kcnt compares against the latched ksteps only, so changing cfg_ksteps mid-tile has no effect.

## Timing
- Reset (async assert, sync release):
  - State is IDLE.
  - busy, done, err, op_ready, mma_issue, mma_first and res_valid are 0.
  - mma_a, mma_b, res_data, res_row and res_col are 0.
- cfg_start at cycle 0: busy=1 and op_ready=1 from cycle 1.
- Last operand handshake at cycle t:
  - mma_issue at t+1.
  - DRAIN covers t+1 .. t+1+LAT.
  - Capture at t+1+LAT; res_valid from t+2+LAT.
- Result handshake at cycle r: op_ready=1 at r+1. For the final result, done=1 and busy=0 at r+1.
- Per output at full throughput: ksteps + LAT + 2 cycles.

## Test plan
- ksteps=1, LAT=2, op_valid and res_ready held high, start at cycle 0 → result n has res_valid at cycle 5+5n. There are 16 results with (row,col) running (0,0)..(3,3), and done pulses at cycle 81 with busy low from 81.
- ksteps=3 with op_valid toggling every other cycle → 48 mma_issue pulses in total. mma_first is high on issues 0,3,6,…; each res_data equals the mma_acc value sampled LAT cycles after the third issue.
- ksteps=2, res_ready held low for 10 cycles in OUT → res_valid, res_data and coordinates stay constant, op_ready=0, and no mma_issue fires; the first cycle after the ready handshake has op_ready=1.
- cfg_start with ksteps=0 → err=1 for exactly one cycle, busy stays 0, and no op_ready.
- cfg_abort during DRAIN of output 5 → IDLE next cycle, res_valid never asserts, and no done. A following start produces result (0,0) first.
- rst_n asserted mid-OUT → all outputs are 0 in the same cycle without a clock edge. After release, the block idles until cfg_start.
